// File: rtl/weight_pkg.sv
// rtl/weight_pkg.sv - shared widths, state codes and saturating weight step for the weight scheduler
package weight_pkg;
  localparam int ADDR_W     = 8;
  localparam int WEIGHT_W   = 8;
  localparam int N_WEIGHTS  = 9;
  localparam int N_WAYS     = 4;
  localparam int ROW_W      = 72;
  localparam int HIST_W     = N_WEIGHTS - 1;
  localparam int STARVE_MAX = 4;
  localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

  localparam logic signed [WEIGHT_W-1:0] WMAX = 8'sh7F;
  localparam logic signed [WEIGHT_W-1:0] WMIN = 8'sh80;

  typedef enum logic [1:0] {
    S_IDLE,
    S_T_RD,
    S_T_CALC,
    S_T_WR
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [HIST_W-1:0] hist;
    logic              taken;
  } train_req_t;

  // +1/-1 step that sticks at the signed rails instead of wrapping
  function automatic logic [WEIGHT_W-1:0] sat_step(input logic [WEIGHT_W-1:0] w, input logic up);
    if (up) return (w == WMAX) ? w : w + 1'b1;
    return (w == WMIN) ? w : w - 1'b1;
  endfunction
endpackage

// File: rtl/weight_update_sched_train_fifo.sv
// rtl/weight_update_sched_train_fifo.sv - 2-entry training request FIFO
module train_fifo
  import weight_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  train_req_t push_data,
  input  logic       pop,
  output train_req_t head,
  output logic       empty,
  output logic       full
);
  train_req_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/weight_update_sched.sv
// rtl/weight_update_sched.sv - arbitrates the weight SRAM between prediction lookups and training RMW
module weight_update_sched
  import weight_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pred_valid,
  output logic                       pred_ready,
  input  logic [N_WAYS*ADDR_W-1:0]   pred_addr,
  output logic                       pred_rsp_valid,
  output logic [N_WAYS*ROW_W-1:0]    pred_weights,
  input  logic                       train_valid,
  output logic                       train_ready,
  input  logic [ADDR_W-1:0]          train_addr,
  input  logic [HIST_W-1:0]          train_hist,
  input  logic                       train_taken,
  output logic                       sram_read_en,
  output logic [N_WAYS*ADDR_W-1:0]   sram_read_addr,
  input  logic [N_WAYS*ROW_W-1:0]    sram_rdata,
  output logic                       sram_write_en,
  output logic [ADDR_W-1:0]          sram_write_addr,
  output logic [ROW_W-1:0]           sram_wdata,
  output logic                       busy
);
  state_t              state, state_nx;
  logic [STARVE_W-1:0] starve_cnt;
  train_req_t          hold_req;
  train_req_t          fifo_head;
  logic                fifo_empty, fifo_full, fifo_pop;
  logic                train_pick, pred_accept;
  logic [ROW_W-1:0]    row_in, new_row;

  assign train_ready     = rst && !fifo_full;
  assign pred_ready      = pred_accept;
  assign pred_weights    = rst ? sram_rdata : '0;
  assign sram_write_addr = sram_write_en ? hold_req.addr : '0;
  assign busy            = !fifo_empty || (state != S_IDLE);
  assign row_in          = sram_rdata[ROW_W-1:0];

  train_fifo u_train_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (train_valid && train_ready),
    .push_data ({train_addr, train_hist, train_taken}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    state_nx       = state;
    train_pick     = 1'b0;
    pred_accept    = 1'b0;
    fifo_pop       = 1'b0;
    sram_read_en   = 1'b0;
    sram_read_addr = '0;
    sram_write_en  = 1'b0;
    unique case (state)
      S_IDLE: begin
        train_pick = !fifo_empty && (!pred_valid || starve_cnt == STARVE_W'(STARVE_MAX));
        if (train_pick) begin
          fifo_pop = 1'b1;
          state_nx = S_T_RD;
        end else if (pred_valid && rst) begin
          pred_accept    = 1'b1;
          sram_read_en   = 1'b1;
          sram_read_addr = pred_addr;
        end
      end
      S_T_RD: begin
        // all four ways on one row keeps the other banks from toggling
        sram_read_en   = 1'b1;
        sram_read_addr = {N_WAYS{hold_req.addr}};
        state_nx       = S_T_CALC;
      end
      S_T_CALC: state_nx = S_T_WR;
      S_T_WR: begin
        sram_write_en = 1'b1;
        state_nx      = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    new_row = '0;
    for (int i = 0; i < HIST_W; i++)
      new_row[i*WEIGHT_W +: WEIGHT_W] =
        sat_step(row_in[i*WEIGHT_W +: WEIGHT_W], hold_req.hist[i] == hold_req.taken);
    new_row[HIST_W*WEIGHT_W +: WEIGHT_W] =
      sat_step(row_in[HIST_W*WEIGHT_W +: WEIGHT_W], hold_req.taken);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      starve_cnt     <= '0;
      hold_req       <= '0;
      pred_rsp_valid <= 1'b0;
      sram_wdata     <= '0;
    end else begin
      state          <= state_nx;
      pred_rsp_valid <= pred_accept;
      if (fifo_pop) hold_req <= fifo_head;
      if (train_pick)
        starve_cnt <= '0;
      else if (pred_accept && !fifo_empty && starve_cnt != STARVE_W'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
      if (state == S_T_CALC) sram_wdata <= new_row;
    end
  end
endmodule
